// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bus port: FSM state encoding and bus size codes.
package sram_like_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_like_port_wen_decode.sv
// Maps CPU byte write enables plus the low address bits onto bus direction,
// transfer size and the aligned low address bits of the request.
module wen_decode
  import sram_like_pkg::*;
(
  input  logic [3:0] cpu_wen,
  input  logic [1:0] cpu_addr_lo,
  output logic       wr,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  // Reads keep the CPU's low address bits; writes derive them from the lane mask.
  // Unsupported masks fall back to a full-word write.
  always_comb begin
    wr      = 1'b1;
    size    = SIZE_W;
    addr_lo = 2'b00;
    case (cpu_wen)
      4'b0000: begin
        wr      = 1'b0;
        size    = SIZE_W;
        addr_lo = cpu_addr_lo;
      end
      4'b1111: begin
        size    = SIZE_W;
        addr_lo = 2'b00;
      end
      4'b0011: begin
        size    = SIZE_H;
        addr_lo = 2'b00;
      end
      4'b1100: begin
        size    = SIZE_H;
        addr_lo = 2'b10;
      end
      4'b0001: begin
        size    = SIZE_B;
        addr_lo = 2'b00;
      end
      4'b0010: begin
        size    = SIZE_B;
        addr_lo = 2'b01;
      end
      4'b0100: begin
        size    = SIZE_B;
        addr_lo = 2'b10;
      end
      4'b1000: begin
        size    = SIZE_B;
        addr_lo = 2'b11;
      end
      default: begin
        wr      = 1'b1;
        size    = SIZE_W;
        addr_lo = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/sram_like_port.sv
// Bridges a single-cycle SRAM-style datapath port onto a request/response
// SRAM-like bus, stalling the datapath until the access completes.
module sram_like_port
  import sram_like_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t     state;
  logic       dec_wr;
  logic [1:0] dec_size;
  logic [1:0] dec_addr_lo;

  wen_decode u_wen_decode (
    .cpu_wen     (cpu_wen),
    .cpu_addr_lo (cpu_addr[1:0]),
    .wr          (dec_wr),
    .size        (dec_size),
    .addr_lo     (dec_addr_lo)
  );

  // Access sequencer: captures the request in IDLE, holds it on the bus until
  // accepted, waits for the response, then releases the datapath for one cycle.
  // Read data is captured only for reads and only when the response is legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_B;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_en) begin
            state     <= S_REQ;
            bus_wr    <= dec_wr;
            bus_size  <= dec_size;
            bus_addr  <= {cpu_addr[ADDR_W-1:2], dec_addr_lo};
            bus_wdata <= cpu_wdata;
          end
        end
        S_REQ: begin
          if (bus_addr_ok) begin
            if (bus_data_ok) begin
              state <= S_RESP;
              if (!bus_wr) begin
                cpu_rdata <= bus_rdata;
              end
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus_data_ok) begin
            state <= S_RESP;
            if (!bus_wr) begin
              cpu_rdata <= bus_rdata;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The request strobe depends on state alone so the handshake inputs never
  // loop back combinationally into it.
  always_comb begin
    bus_req = (state == S_REQ);
  end

  // The datapath is frozen from the moment it asks until the response cycle.
  always_comb begin
    cpu_stall = ((state == S_IDLE) && cpu_en) || (state == S_REQ) || (state == S_WAIT);
  end

endmodule

// File: tb/tb_sram_like_port.sv
// Directed bench for sram_like_port: a vector table of single accesses against
// an instantly-responding slave, plus hand sequences for delays, back-to-back
// accesses, reset mid-access and the illegal write-enable pattern.
module tb_sram_like_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit illegal_allowed = 1'b0;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  sram_like_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  // Free-running clock and a cycle label used to measure latencies.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic bit isLegal(input logic [3:0] wen);
    case (wen)
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: isLegal = 1'b1;
      default: isLegal = 1'b0;
    endcase
  endfunction

  // The datapath must never present an unsupported lane mask unless a test says so.
  always @(negedge clk) begin
    if (!rst && cpu_en === 1'b1 && !isLegal(cpu_wen) && !illegal_allowed) begin
      failures++;
      $display("[TB] FAIL illegal_wen actual=%b required=legal mask", cpu_wen);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Runs one access starting just after a falling edge. The slave accepts after
  // addr_delay REQ cycles and answers data_delay cycles after acceptance.
  task automatic applyStimulus(
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  int          addr_delay,
    input  int          data_delay,
    input  bit          keep_en,
    output int          stall_n,
    output int          req_n,
    output int          first_req,
    output int          resp_cyc,
    output logic        got_wr,
    output logic [1:0]  got_size,
    output logic [31:0] got_addr,
    output logic [31:0] got_wdata,
    output logic [31:0] got_rdata
  );
    bit accepted;
    bit done;
    int accepted_at;
    cpu_en    = 1'b1;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stall_n   = 0;
    req_n     = 0;
    first_req = -1;
    resp_cyc  = -1;
    got_wr    = 1'b0;
    got_size  = 2'd0;
    got_addr  = 32'h0;
    got_wdata = 32'h0;
    got_rdata = 32'h0;
    accepted  = 1'b0;
    accepted_at = 0;
    done      = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (bus_req) begin
        if (req_n == 0) begin
          first_req = cycle;
          got_wr    = bus_wr;
          got_size  = bus_size;
          got_addr  = bus_addr;
          got_wdata = bus_wdata;
        end
        req_n++;
      end
      if (!cpu_stall) begin
        done      = 1'b1;
        resp_cyc  = cycle;
        got_rdata = cpu_rdata;
      end else begin
        stall_n++;
      end
      if (!done) begin
        if (bus_req && !accepted && (req_n - 1) == addr_delay) begin
          bus_addr_ok = 1'b1;
          accepted    = 1'b1;
          accepted_at = c;
        end
        if (accepted && c == accepted_at + data_delay) begin
          bus_data_ok = 1'b1;
          bus_rdata   = rdata;
        end
      end
      @(posedge clk);
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'hDEAD_BEEF;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL access_timeout actual=no RESP required=RESP within 60 cycles");
    end
    if (!keep_en) begin
      cpu_en = 1'b0;
    end
  endtask

  initial begin
    int          stall_n, req_n, first_req, resp_cyc;
    int          stall_b, req_b, first_req_b, resp_b;
    logic        got_wr;
    logic [1:0]  got_size;
    logic [31:0] got_addr, got_wdata, got_rdata;

    vecs[0] = '{4'b0000, 32'hBFC0_0000, 32'h0000_0000, 32'h2408_0001, 1'b0, 2'd2, 32'hBFC0_0000, 32'h2408_0001};
    vecs[1] = '{4'b0100, 32'h8000_1003, 32'h00AB_0000, 32'h1111_1111, 1'b1, 2'd0, 32'h8000_1002, 32'h2408_0001};
    vecs[2] = '{4'b1100, 32'h8000_2001, 32'hBEEF_0000, 32'h2222_2222, 1'b1, 2'd1, 32'h8000_2002, 32'h2408_0001};
    vecs[3] = '{4'b0011, 32'h8000_2003, 32'h0000_CAFE, 32'h3333_3333, 1'b1, 2'd1, 32'h8000_2000, 32'h2408_0001};
    vecs[4] = '{4'b1111, 32'h8000_3007, 32'h0123_4567, 32'h4444_4444, 1'b1, 2'd2, 32'h8000_3004, 32'h2408_0001};
    vecs[5] = '{4'b0001, 32'h8000_0002, 32'h0000_0011, 32'h5555_5555, 1'b1, 2'd0, 32'h8000_0000, 32'h2408_0001};
    vecs[6] = '{4'b0010, 32'h8000_0000, 32'h0000_2200, 32'h6666_6666, 1'b1, 2'd0, 32'h8000_0001, 32'h2408_0001};
    vecs[7] = '{4'b1000, 32'h8000_0000, 32'h3300_0000, 32'h7777_7777, 1'b1, 2'd0, 32'h8000_0003, 32'h2408_0001};
    vecs[8] = '{4'b0000, 32'h8000_0006, 32'h0000_0000, 32'h1234_5678, 1'b0, 2'd2, 32'h8000_0006, 32'h1234_5678};

    rst         = 1'b1;
    cpu_en      = 1'b0;
    cpu_wen     = 4'b0000;
    cpu_addr    = 32'h0;
    cpu_wdata   = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_bus_req",   32'(bus_req),   32'h0);
    checkOutput("reset_bus_wr",    32'(bus_wr),    32'h0);
    checkOutput("reset_bus_size",  32'(bus_size),  32'h0);
    checkOutput("reset_bus_addr",  bus_addr,       32'h0);
    checkOutput("reset_bus_wdata", bus_wdata,      32'h0);
    checkOutput("reset_cpu_rdata", cpu_rdata,      32'h0);
    checkOutput("reset_stall_idle", 32'(cpu_stall), 32'h0);
    cpu_en = 1'b1;
    #1;
    checkOutput("idle_en_stall", 32'(cpu_stall), 32'h1);
    cpu_en = 1'b0;
    @(negedge clk);

    // Table of single accesses with an instantly-responding slave.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0, 1'b0,
                    stall_n, req_n, first_req, resp_cyc,
                    got_wr, got_size, got_addr, got_wdata, got_rdata);
      checkOutput($sformatf("v%0d_bus_wr", i),    32'(got_wr),   32'(vecs[i].exp_wr));
      checkOutput($sformatf("v%0d_bus_size", i),  32'(got_size), 32'(vecs[i].exp_size));
      checkOutput($sformatf("v%0d_bus_addr", i),  got_addr,      vecs[i].exp_addr);
      checkOutput($sformatf("v%0d_bus_wdata", i), got_wdata,     vecs[i].wdata);
      checkOutput($sformatf("v%0d_req_cycles", i), 32'(req_n),   32'd1);
      checkOutput($sformatf("v%0d_stall_cycles", i), 32'(stall_n), 32'd2);
      checkOutput($sformatf("v%0d_cpu_rdata", i), got_rdata,     vecs[i].exp_rdata);
    end

    // Slow slave: addr_ok after 3 extra REQ cycles, data_ok 2 cycles later.
    applyStimulus(4'b0000, 32'h9000_0010, 32'h0, 32'h55AA_33CC, 3, 2, 1'b0,
                  stall_n, req_n, first_req, resp_cyc,
                  got_wr, got_size, got_addr, got_wdata, got_rdata);
    checkOutput("slow_req_cycles",   32'(req_n),   32'd4);
    checkOutput("slow_stall_cycles", 32'(stall_n), 32'd7);
    checkOutput("slow_cpu_rdata",    got_rdata,    32'h55AA_33CC);
    checkOutput("slow_resp_after_req", 32'(resp_cyc - first_req), 32'd6);

    // Back-to-back reads with cpu_en held high across the RESP cycle.
    applyStimulus(4'b0000, 32'hA000_0000, 32'h0, 32'h0000_0A0A, 0, 0, 1'b1,
                  stall_n, req_n, first_req, resp_cyc,
                  got_wr, got_size, got_addr, got_wdata, got_rdata);
    checkOutput("b2b_first_rdata", got_rdata, 32'h0000_0A0A);
    checkOutput("b2b_first_reqs",  32'(req_n), 32'd1);
    applyStimulus(4'b0000, 32'hA000_0004, 32'h0, 32'h0000_0B0B, 0, 0, 1'b0,
                  stall_b, req_b, first_req_b, resp_b,
                  got_wr, got_size, got_addr, got_wdata, got_rdata);
    checkOutput("b2b_second_rdata", got_rdata, 32'h0000_0B0B);
    checkOutput("b2b_second_addr",  got_addr,  32'hA000_0004);
    checkOutput("b2b_second_reqs",  32'(req_b), 32'd1);
    checkOutput("b2b_req_gap",      32'(first_req_b - resp_cyc), 32'd2);

    // Reset while waiting for read data, then a stray data_ok must be ignored.
    cpu_en   = 1'b1;
    cpu_wen  = 4'b0000;
    cpu_addr = 32'hC000_0000;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstwait_req_phase", 32'(bus_req), 32'h1);
    bus_addr_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_addr_ok = 1'b0;
    cpu_en      = 1'b0;
    #1;
    checkOutput("rstwait_wait_req",   32'(bus_req),   32'h0);
    checkOutput("rstwait_wait_stall", 32'(cpu_stall), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstwait_after_req",   32'(bus_req),   32'h0);
    checkOutput("rstwait_after_rdata", cpu_rdata,      32'h0);
    checkOutput("rstwait_after_stall", 32'(cpu_stall), 32'h0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    checkOutput("spurious_rdata", cpu_rdata,      32'h0);
    checkOutput("spurious_req",   32'(bus_req),   32'h0);
    checkOutput("spurious_stall", 32'(cpu_stall), 32'h0);
    @(negedge clk);

    // Unsupported lane mask falls back to a word write.
    illegal_allowed = 1'b1;
    applyStimulus(4'b0101, 32'h8000_4001, 32'h00FF_00FF, 32'h0, 0, 0, 1'b0,
                  stall_n, req_n, first_req, resp_cyc,
                  got_wr, got_size, got_addr, got_wdata, got_rdata);
    illegal_allowed = 1'b0;
    checkOutput("illegal_bus_wr",   32'(got_wr),   32'h1);
    checkOutput("illegal_bus_size", 32'(got_size), 32'h2);
    checkOutput("illegal_rdata_held", got_rdata,   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
